mem_cmd_sequencer: RTL and testbench
====================================

// Module: mem_cmd_sequencer
// PURPOSE
//  Upstream command stage for the 4x8-bit banked 16-entry memory array.
//  - Accepts read/write commands over a valid/ready interface and buffers them in a small FIFO.
//  - Issues one command per cycle to the array as registered read/write/address/data_in strobes.
//  - Captures the array's data_out for reads and returns it with a one-cycle rsp_valid pulse.
// PARAMETERS
//  DEPTH       4   command FIFO entries; power of 2, >=2
//  DATA_W      32  data width; matches 4 byte lanes of the array
//  ADDR_W      4   address width; 16 entries
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  cmd_valid     in   1       command present
//  cmd_ready     out  1       FIFO can accept; = !full
//  cmd_op        in   2       00 NOP, 01 WRITE, 10 READ, 11 FILL
//  cmd_addr      in   ADDR_W  target address (FILL: start address)
//  cmd_data      in   DATA_W  write/fill data
//  mem_read      out  1       to array read
//  mem_write     out  1       to array write
//  mem_address   out  ADDR_W  to array address
//  mem_data_in   out  DATA_W  to array data_in
//  mem_data_out  in   DATA_W  from array data_out
//  rsp_valid     out  1       read data valid, 1-cycle pulse
//  rsp_addr      out  ADDR_W  address of the returned read
//  rsp_data      out  DATA_W  read data
//  busy          out  1       FIFO non-empty, or a command in progress
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - FIFO emptied; FSM to IDLE; in-progress FILL aborted.
//   - mem_read, mem_write, rsp_valid, busy = 0.
//   - mem_address, mem_data_in, rsp_addr, rsp_data = 0.
//   - cmd_ready=1 from the cycle after reset.
//  FIFO:
//   - Push on cmd_valid&&cmd_ready.
//   - cmd_ready is low when full, even if a pop occurs in the same cycle.
//   - Pointers wrap modulo DEPTH.
//  FSM states IDLE, ISSUE, FILL:
//   - IDLE/ISSUE, FIFO non-empty: pop head; register mem_* strobes for exactly one cycle; state ISSUE.
//   - FIFO empty: go to IDLE with mem_read=mem_write=0. Back-to-back commands issue every cycle.
//   - WRITE: mem_write=1, mem_address=addr, mem_data_in=data for one cycle.
//   - READ: mem_read=1, mem_address=addr for one cycle. At the edge ending that cycle,
//     capture mem_data_out into rsp_data and addr into rsp_addr, and pulse rsp_valid next cycle.
//   - Read latency: 2 cycles from pop to rsp_valid.
//   - NOP: popped; no strobes; costs one cycle.
//  Ordering and hazards:
//   - Commands execute strictly in FIFO order.
//   - A READ after a WRITE to the same address returns the new data.
//  Width rules:
//   - Address arithmetic is ADDR_W bits and wraps 15->0.
//   - No data arithmetic.
//  Reset mid-operation:
//   - Strobes drop on the cycle after the reset edge.
//   - A pending rsp_valid is cancelled.
// CONFIGURATION
//  Macro MEM_CMD_SEQ_FILL_EN:
//   - Defined, FILL: FSM enters FILL and writes cmd_data to 16 consecutive addresses,
//     start..start+15 wrapping, one per cycle (mem_write=1 for 16 cycles).
//   - During FILL the FIFO is not popped but still accepts pushes.
//   - Next command issues on the cycle after the 16th write.
//   - Not defined: op 11 is treated as NOP; FILL state and its counter are not compiled.
// TESTING
//  1. rst for 2 cycles -> all outputs 0; then cmd_ready=1, busy=0.
//  2. WRITE a=3 d=DEADBEEF, then READ a=3, back-to-back ->
//     - mem_write one cycle, then mem_read one cycle.
//     - rsp_valid 2 cycles after the READ pop; rsp_data=DEADBEEF, rsp_addr=3.
//  3. Push 5 commands with the consumer stalled by FILL (DEPTH=4) -> cmd_ready=0 after 4 accepted;
//     5th held; all 4 later issue in order.
//  4. WRITE a=15 then FILL a=14 d=A5A5A5A5 (FILL_EN) -> writes at 14,15,0..13; 16 write cycles;
//     READ a=15 returns A5A5A5A5.
//  5. Assert rst on the READ issue cycle -> no rsp_valid; FIFO empty; strobes 0 next cycle.
//  6. FILL without FILL_EN -> no mem_write; next command issues the cycle after.

Source files
------------

// File: rtl/mem_cmd_sequencer.sv
// Command FIFO and issue sequencer in front of the 4x8-bit banked 16-entry memory array.
// Optional FILL command is compiled in only when MEM_CMD_SEQ_FILL_EN is defined.
module mem_cmd_sequencer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_FILL  = 2'b11;

`ifdef MEM_CMD_SEQ_FILL_EN
    typedef enum logic [1:0] {IDLE, ISSUE, FILL} state_t;
    logic [3:0] fill_cnt;
`else
    typedef enum logic [1:0] {IDLE, ISSUE} state_t;
`endif

    state_t state;

    logic [1:0]        fifo_op   [DEPTH];
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [1:0]        head_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // The head is only consumed when the sequencer is free; an active FILL holds it off.
    always_comb begin
        full      = (count == CNT_W'(DEPTH));
        empty     = (count == '0);
        cmd_ready = !full;
        push      = cmd_valid && !full;
`ifdef MEM_CMD_SEQ_FILL_EN
        pop       = !empty && !((state == FILL) && (fill_cnt != '0));
`else
        pop       = !empty;
`endif
        busy      = !empty || (state != IDLE);
        head_op   = fifo_op[rd_ptr];
        head_addr = fifo_addr[rd_ptr];
        head_data = fifo_data[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_op[wr_ptr]   <= cmd_op;
                fifo_addr[wr_ptr] <= cmd_addr;
                fifo_data[wr_ptr] <= cmd_data;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Strobes are registered and live for one cycle; a read's data is captured at the end of its strobe cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
`ifdef MEM_CMD_SEQ_FILL_EN
            fill_cnt    <= '0;
`endif
        end else begin
            rsp_valid <= mem_read;
            if (mem_read) begin
                rsp_addr <= mem_address;
                rsp_data <= mem_data_out;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (pop) begin
                state <= ISSUE;
                case (head_op)
                    OP_WRITE: begin
                        mem_write   <= 1'b1;
                        mem_address <= head_addr;
                        mem_data_in <= head_data;
                    end
                    OP_READ: begin
                        mem_read    <= 1'b1;
                        mem_address <= head_addr;
                    end
`ifdef MEM_CMD_SEQ_FILL_EN
                    OP_FILL: begin
                        mem_write   <= 1'b1;
                        mem_address <= head_addr;
                        mem_data_in <= head_data;
                        fill_cnt    <= 4'd15;
                        state       <= FILL;
                    end
                    OP_NOP: begin
                    end
`else
                    OP_NOP, OP_FILL: begin
                    end
`endif
                    default: begin
                    end
                endcase
            end
`ifdef MEM_CMD_SEQ_FILL_EN
            else if ((state == FILL) && (fill_cnt != '0)) begin
                mem_write   <= 1'b1;
                mem_address <= mem_address + ADDR_W'(1);
                fill_cnt    <= fill_cnt - 4'd1;
            end
`endif
            else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Self-checking bench for mem_cmd_sequencer: directed timing steps plus a randomized run
// checked against an in-order command-expansion model with its own golden memory.
`timescale 1ns/1ps
module tb_mem_cmd_sequencer;

    localparam int TRACE_N = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        rsp_valid;
    logic [3:0]  rsp_addr;
    logic [31:0] rsp_data;
    logic        busy;

    mem_cmd_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .rsp_valid    (rsp_valid),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] din;
        logic        rv;
        logic [3:0]  raddr;
        logic [31:0] rdata;
        logic        busy;
        logic        ready;
    } trace_t;

    typedef struct packed {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } ev_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } rsp_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        logging = 1'b0;
    trace_t      trace [TRACE_N];
    logic [31:0] array_mem [16];
    logic [31:0] golden_mem [16];
    ev_t         exp_ev[$];
    ev_t         obs_ev[$];
    rsp_t        exp_rsp[$];
    rsp_t        obs_rsp[$];

    // Behavioural stand-in for the memory array: combinational read, write on the clock edge.
    always @(posedge clk) begin
        if (mem_write === 1'b1) array_mem[mem_address] <= mem_data_in;
    end
    assign mem_data_out = array_mem[mem_address];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < TRACE_N)
            trace[cyc] <= {mem_read, mem_write, mem_address, mem_data_in, rsp_valid,
                           rsp_addr, rsp_data, busy, cmd_ready};
        if (logging && rst === 1'b0) begin
            if (mem_write === 1'b1) obs_ev.push_back({1'b1, mem_address, mem_data_in});
            if (mem_read === 1'b1)  obs_ev.push_back({1'b0, mem_address, 32'h0});
            if (rsp_valid === 1'b1) obs_rsp.push_back({rsp_addr, rsp_data});
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Each accepted command expands, in order, into the array accesses it must cause.
    task automatic model_accept(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d);
        case (op)
            2'b01: begin
                golden_mem[a] = d;
                exp_ev.push_back({1'b1, a, d});
            end
            2'b10: begin
                exp_ev.push_back({1'b0, a, 32'h0});
                exp_rsp.push_back({a, golden_mem[a]});
            end
`ifdef MEM_CMD_SEQ_FILL_EN
            2'b11: begin
                for (int i = 0; i < 16; i++) begin
                    golden_mem[a + 4'(i)] = d;
                    exp_ev.push_back({1'b1, 4'(a + 4'(i)), d});
                end
            end
`endif
            default: begin
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [31:0] d,
                                 output int edge_idx);
        logic accepted;
        accepted  = 1'b0;
        edge_idx  = -1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 100 && !accepted; i++) begin
            accepted = cmd_ready;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (accepted) begin
            edge_idx = cyc;
            model_accept(op, a, d);
        end
        checkOutput("accept", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy !== 1'b0 || rsp_valid !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          p1, p2, pn, px, pw, pf, pr;
        int          w [5];
        logic [1:0]  op;
        logic [3:0]  a;
        logic [31:0] d;

        for (int i = 0; i < 16; i++) begin
            array_mem[i]  = 32'h0;
            golden_mem[i] = 32'h0;
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_addr = 4'h0;
        cmd_data = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_strobes", 64'({mem_read, mem_write, rsp_valid, busy}), 64'd0);
        checkOutput("rst_mem_address", 64'(mem_address), 64'd0);
        checkOutput("rst_mem_data_in", 64'(mem_data_in), 64'd0);
        checkOutput("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b0;
        logging = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(cmd_ready), 64'd1);
        checkOutput("post_rst_busy", 64'(busy), 64'd0);

        // WRITE then READ back-to-back to the same address.
        applyStimulus(2'b01, 4'd3, 32'hDEADBEEF, p1);
        applyStimulus(2'b10, 4'd3, 32'h0, p2);
        drain();
        checkOutput("t2_push_b2b", 64'(p2 - p1), 64'd1);
        checkOutput("t2_write", 64'({trace[p1+1].wr, trace[p1+1].rd, trace[p1+1].addr, trace[p1+1].din}),
                    64'({1'b1, 1'b0, 4'd3, 32'hDEADBEEF}));
        checkOutput("t2_read", 64'({trace[p2+1].wr, trace[p2+1].rd, trace[p2+1].addr}),
                    64'({1'b0, 1'b1, 4'd3}));
        checkOutput("t2_no_early_rsp", 64'(trace[p2+1].rv), 64'd0);
        checkOutput("t2_rsp", 64'({trace[p2+2].rv, trace[p2+2].rd, trace[p2+2].raddr, trace[p2+2].rdata}),
                    64'({1'b1, 1'b0, 4'd3, 32'hDEADBEEF}));
        checkOutput("t2_rsp_pulse", 64'(trace[p2+3].rv), 64'd0);

        // NOP costs one cycle with no strobes.
        applyStimulus(2'b00, 4'd7, 32'h12345678, pn);
        applyStimulus(2'b10, 4'd3, 32'h0, px);
        drain();
        checkOutput("nop_no_strobe", 64'({trace[pn+1].wr, trace[pn+1].rd, trace[pn+1].busy}), 64'({1'b0, 1'b0, 1'b1}));
        checkOutput("nop_next_read", 64'({trace[pn+2].rd, trace[pn+2].addr}), 64'({1'b1, 4'd3}));
        checkOutput("nop_rsp", 64'({trace[pn+3].rv, trace[pn+3].rdata}), 64'({1'b1, 32'hDEADBEEF}));

`ifdef MEM_CMD_SEQ_FILL_EN
        // FILL wraps 14,15,0..13; the following READ sees the fill data.
        applyStimulus(2'b01, 4'd15, 32'h11111111, pw);
        applyStimulus(2'b11, 4'd14, 32'hA5A5A5A5, pf);
        applyStimulus(2'b10, 4'd15, 32'h0, pr);
        drain();
        checkOutput("t4_first_write", 64'({trace[pw+1].wr, trace[pw+1].addr}), 64'({1'b1, 4'd15}));
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("t4_fill%0d", i),
                        64'({trace[pw+2+i].wr, trace[pw+2+i].rd, trace[pw+2+i].addr, trace[pw+2+i].din}),
                        64'({1'b1, 1'b0, 4'(14 + i), 32'hA5A5A5A5}));
        checkOutput("t4_read_after", 64'({trace[pw+18].rd, trace[pw+18].wr, trace[pw+18].addr}), 64'({1'b1, 1'b0, 4'd15}));
        checkOutput("t4_rsp", 64'({trace[pw+19].rv, trace[pw+19].raddr, trace[pw+19].rdata}),
                    64'({1'b1, 4'd15, 32'hA5A5A5A5}));

        // A FILL stalls the consumer so the FIFO fills and back-pressures the fifth command.
        applyStimulus(2'b11, 4'd0, 32'h0F0F0F0F, pf);
        for (int i = 0; i < 5; i++)
            applyStimulus(2'b01, 4'(i + 1), 32'(i + 100), w[i]);
        drain();
        checkOutput("t3_four_accepted", 64'(w[3] - pf), 64'd4);
        checkOutput("t3_full_ready", 64'({trace[pf+4].ready, trace[pf+16].ready}), 64'd0);
        checkOutput("t3_fifth_edge", 64'(w[4] - pf), 64'd18);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t3_order%0d", i), 64'({trace[pf+17+i].wr, trace[pf+17+i].addr, trace[pf+17+i].din}),
                        64'({1'b1, 4'(i + 1), 32'(i + 100)}));
`else
        // Op 11 without the fill feature behaves as a NOP.
        applyStimulus(2'b11, 4'd2, 32'hCAFEF00D, px);
        applyStimulus(2'b01, 4'd5, 32'h00005555, pw);
        drain();
        checkOutput("t6_fill_nop", 64'({trace[px+1].wr, trace[px+1].rd}), 64'd0);
        checkOutput("t6_next_write", 64'({trace[px+2].wr, trace[px+2].addr, trace[px+2].din}),
                    64'({1'b1, 4'd5, 32'h00005555}));
`endif

        // Randomized traffic against the command-expansion model.
        for (int k = 0; k < 60; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = 4'($urandom_range(0, 7));
            d  = $urandom();
            applyStimulus(op, a, d, px);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        logging = 1'b0;
        checkOutput("ev_count", 64'(obs_ev.size()), 64'(exp_ev.size()));
        for (int i = 0; i < exp_ev.size() && i < obs_ev.size(); i++)
            checkOutput($sformatf("ev%0d", i), 64'(obs_ev[i]), 64'(exp_ev[i]));
        checkOutput("rsp_count", 64'(obs_rsp.size()), 64'(exp_rsp.size()));
        for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
            checkOutput($sformatf("rsp%0d", i), 64'(obs_rsp[i]), 64'(exp_rsp[i]));

        // Reset during the read strobe cancels its response and flushes the queued write.
        applyStimulus(2'b10, 4'd3, 32'h0, p1);
        applyStimulus(2'b01, 4'd9, 32'h77777777, p2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_read_was_live", 64'(trace[p1+1].rd), 64'd1);
        checkOutput("t5_after_rst", 64'({trace[p1+2].rd, trace[p1+2].wr, trace[p1+2].rv, trace[p1+2].busy, trace[p1+2].ready}),
                    64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
        checkOutput("t5_no_late", 64'({trace[p1+3].rv, trace[p1+3].wr, trace[p1+4].wr, trace[p1+4].rd}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
